// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate response checker: FSM state
// encoding, common 2-input truth tables and a one-hot helper.
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Expected output indexed by {a,b}: bit[{a,b}] is the gate result.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/gate_response_checker_if.sv
// Observe-side bundle for the gate response checker: the stimulus side drives
// run control and the sampled gate pins, the checker returns run status.
interface gate_response_checker_if #(
  parameter int unsigned ERR_W = 8
);

  logic             start;
  logic             sample_valid;
  logic             a;
  logic             b;
  logic             y;

  logic             busy;
  logic             done;
  logic             pass;
  logic [3:0]       covered;
  logic [ERR_W-1:0] err_count;
  logic             first_err_valid;
  logic [1:0]       first_err_idx;

  modport master (
    output start, sample_valid, a, b, y,
    input  busy, done, pass, covered, err_count, first_err_valid, first_err_idx
  );

  modport slave (
    input  start, sample_valid, a, b, y,
    output busy, done, pass, covered, err_count, first_err_valid, first_err_idx
  );

endinterface

// File: rtl/gate_check_sat_counter.sv
// Saturating up-counter; clear has priority over increment and the count
// sticks at all-ones instead of wrapping.
module gate_check_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/gate_response_checker.sv
// Judges a 2-input gate's output against a truth table, tracks coverage of
// all four input combinations and reports done/pass once all are seen.
module gate_response_checker
  import gate_check_pkg::*;
#(
  parameter logic [3:0]  TRUTH_TABLE = TT_AND,
  parameter int unsigned ERR_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  gate_response_checker_if.slave bus
);

  state_t           state;
  state_t           state_nx;
  logic             clr_run;
  logic             take;
  logic             complete;
  logic [1:0]       idx;
  logic             mismatch;

  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [3:0]       covered_q;
  logic             fev_q;
  logic [1:0]       fei_q;
  logic [ERR_W-1:0] err_count;

  assign idx      = {bus.a, bus.b};
  assign mismatch = (bus.y != TRUTH_TABLE[idx]);

  // start always wins over a coincident sample, in every state.
  always_comb begin
    state_nx = state;
    clr_run  = 1'b0;
    take     = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          clr_run  = 1'b1;
          state_nx = CHECK;
        end
      end
      CHECK: begin
        if (bus.start) begin
          clr_run = 1'b1;
        end else if (bus.sample_valid) begin
          take = 1'b1;
          if ((covered_q | onehot4(idx)) == 4'b1111) begin
            complete = 1'b1;
            state_nx = DONE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      covered_q <= '0;
      fev_q     <= 1'b0;
      fei_q     <= '0;
    end else begin
      state  <= state_nx;
      busy_q <= (state_nx == CHECK);
      done_q <= (state_nx == DONE);
      if (clr_run) begin
        pass_q    <= 1'b0;
        covered_q <= '0;
        fev_q     <= 1'b0;
        fei_q     <= '0;
      end else if (take) begin
        covered_q <= covered_q | onehot4(idx);
        if (mismatch && !fev_q) begin
          fev_q <= 1'b1;
          fei_q <= idx;
        end
        // The completing sample counts: pass needs no prior and no current error.
        if (complete) begin
          pass_q <= (err_count == '0) && !mismatch;
        end
      end
    end
  end

  gate_check_sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .clr   (rst | clr_run),
    .inc   (take & mismatch),
    .count (err_count)
  );

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.covered         = covered_q;
  assign bus.err_count       = err_count;
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_idx   = fei_q;

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
Synthesizable response checker for a 2-input logic gate under test. It samples the gate's inputs and output, compares each output against a parameterised 4-entry truth table, and tracks coverage of all four input combinations. It counts mismatches and reports done/pass once every combination has been seen. It sits on the observe side of a gate DUT: a stimulus source drives a/b, the DUT produces y, and this block judges y. It lets gate benches and FPGA smoke tests self-check in hardware without $display inspection.

Parameters:
TRUTH_TABLE, 4'b1000, expected y indexed by {a,b}; bit[{a,b}] = expected output (default = AND)
ERR_W, 8, width of mismatch counter

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin/restart a check run (single-cycle pulse)
sample_valid  input  1  a, b, y are settled and valid this cycle
a  input  1  gate input A as driven to DUT
b  input  1  gate input B as driven to DUT
y  input  1  DUT output
busy  output  1  high while in CHECK
done  output  1  high in DONE; run complete
pass  output  1  valid when done=1; 1 = zero mismatches
covered  output  4  bit[{a,b}] set once that combination has been sampled
err_count  output  ERR_W  mismatches this run, saturating at all-ones
first_err_valid  output  1  at least one mismatch captured this run
first_err_idx  output  2  {a,b} of first mismatch; 0 when first_err_valid=0

Behaviour:
- All outputs registered. Every output resets to 0; state resets to IDLE.
- Reset takes priority over everything, including mid-run. The run is abandoned, with no done or pass.
- States: IDLE, CHECK, DONE.
- IDLE: sample_valid is ignored. start -> CHECK on the next edge. covered, err_count, first_err_*, pass and done are all cleared on that edge.
- CHECK:
  - busy=1.
  - On sample_valid: idx={a,b}; exp=TRUTH_TABLE[idx]; mismatch = (y != exp).
  - covered[idx] <= 1.
  - On mismatch, err_count increments, saturating (no wrap at 2^ERR_W-1).
  - On the first mismatch of the run, first_err_idx <= idx and first_err_valid <= 1. Later mismatches do not overwrite it.
  - Repeated samples of an already-covered idx are still checked and counted.
- CHECK -> DONE on the edge where (covered | onehot(idx)) == 4'b1111 with sample_valid=1.
  - The completing sample is included in err_count and pass.
  - On that same edge: pass <= (next err_count == 0), done <= 1, busy <= 0.
  - Latency: done rises 1 cycle after the completing sample.
- start during CHECK: restart. All run state is cleared, the block stays in CHECK, and any sample_valid in that cycle is discarded.
- start during DONE: same as start in IDLE (clear, -> CHECK).
- DONE: done, pass, covered, err_count and first_err_* hold until start or rst. sample_valid is ignored.
- No sample_valid for any number of cycles: the block stays in CHECK. There is no timeout.
- start and sample_valid together in IDLE or DONE: start wins and the sample is dropped.

Decomposition:
- Shared package gate_check_pkg:
  - State encoding constants: IDLE=2'd0, CHECK=2'd1, DONE=2'd2.
  - Truth-table constants: TT_AND=4'b1000, TT_OR=4'b1110, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XOR=4'b0110, TT_XNOR=4'b1001.
- One natural sub-module: gate_check_sat_counter.
  - Parameter W; inputs clr, inc; output count.
  - Saturating at all-ones; clr has priority over inc.
  - Used for err_count.

Test Plan:
1. Correct AND DUT, samples {a,b}=00,01,10,11 with y=0,0,0,1 -> done=1 one cycle after 4th sample, pass=1, err_count=0, covered=4'b1111, first_err_valid=0.
2. Faulty DUT (y stuck at 1), same sequence -> err_count=3, first_err_idx=2'b00, first_err_valid=1, pass=0, done=1.
3. Samples 11,11,00,01 (3 combos), then idle 20 cycles -> busy=1, done=0, covered=4'b1011; a further 10 with y=0 -> done=1, pass=1.
4. ERR_W=2, stuck-at-1 DUT, 6 samples of idx 00 then 01,10,11 -> err_count saturates at 2'b11, pass=0.
5. rst asserted after 2 valid samples -> next cycle all outputs 0, IDLE. sample_valid without start -> no change. start then the full correct sequence -> pass=1.
6. start pulsed mid-run after a mismatch, coinciding with sample_valid -> err_count=0, covered=0, first_err_valid=0. That sample is dropped. The full correct sequence then gives pass=1.
